// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM client arbiter: FSM states, read-tag payload and width helper.
package sram_arb_pkg;

    localparam int unsigned MAX_CLIENTS = 8;
    localparam int unsigned TAG_OWNER_W = 3;

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_GRANT,
        S_ARB_SWITCH
    } arb_state_t;

    typedef struct packed {
        logic                   valid;
        logic [TAG_OWNER_W-1:0] owner;
    } read_tag_t;

    function automatic int unsigned CLIENT_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_arb_picker.sv
// Combinational winner select: lowest requester, or first requester after the last owner.
module sram_arb_picker
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4
)(
    input  logic [NUM_CLIENTS-1:0]           req,
    input  logic                             mode,
    input  logic [CLIENT_W(NUM_CLIENTS)-1:0] last_owner,
    output logic [CLIENT_W(NUM_CLIENTS)-1:0] winner,
    output logic                             found
);

    localparam int unsigned CW = CLIENT_W(NUM_CLIENTS);

    int unsigned k_idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        k_idx  = 0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            k_idx = mode ? (32'(last_owner) + 32'd1 + i) % NUM_CLIENTS : i;
            if (!found && req[CW'(k_idx)]) begin
                found  = 1'b1;
                winner = CW'(k_idx);
            end
        end
    end

endmodule

// File: rtl/sram_client_arbiter.sv
// N-client arbiter for the shared SRAM port: request/grant handshake, burst limit,
// one dead cycle on every ownership change, and owner-tagged read-data strobes.
module sram_client_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS    = 4,
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned MAX_BURST      = 256,
    parameter int unsigned DEFAULT_CLIENT = NUM_CLIENTS - 1
)(
    input  logic                             CLOCK_50_I,
    input  logic                             resetn,
    input  logic                             mode_i,
    input  logic [NUM_CLIENTS-1:0]           req_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]    addr_i,
    input  logic [NUM_CLIENTS*DATA_W-1:0]    wdata_i,
    input  logic [NUM_CLIENTS-1:0]           we_n_i,
    output logic [NUM_CLIENTS-1:0]           gnt_o,
    output logic [NUM_CLIENTS-1:0]           rvalid_o,
    output logic [CLIENT_W(NUM_CLIENTS)-1:0] owner_o,
    output logic                             busy_o,
    output logic [ADDR_W-1:0]                SRAM_address,
    output logic [DATA_W-1:0]                SRAM_write_data,
    output logic                             SRAM_we_n
);

    localparam int unsigned CW      = CLIENT_W(NUM_CLIENTS);
    localparam int unsigned BURST_W = $clog2(MAX_BURST);
    localparam int unsigned PIPE_D  = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    arb_state_t           state_q, state_d;
    logic [NUM_CLIENTS-1:0] gnt_d;
    logic [CW-1:0]        owner_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [CW-1:0]        winner;
    logic                 found;
    logic                 owner_req;
    logic                 others_req;
    logic                 burst_last;
    read_tag_t            tag_in;
    read_tag_t            tag_tail;
    read_tag_t            tag_pipe [PIPE_D];

    sram_arb_picker #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_picker (
        .req        (req_i),
        .mode       (mode_i),
        .last_owner (owner_o),
        .winner     (winner),
        .found      (found)
    );

    assign owner_req  = req_i[owner_o];
    assign others_req = |(req_i & ~gnt_o);
    assign burst_last = (burst_q == BURST_W'(MAX_BURST - 1));

    // Next-state and next-grant logic; arbitration only happens in IDLE and SWITCH.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_o;
        owner_d = owner_o;
        burst_d = burst_q;
        case (state_q)
            S_ARB_IDLE, S_ARB_SWITCH: begin
                gnt_d   = '0;
                burst_d = '0;
                state_d = S_ARB_IDLE;
                if (found) begin
                    state_d = S_ARB_GRANT;
                    gnt_d   = NUM_CLIENTS'(1) << winner;
                    owner_d = winner;
                end
            end
            S_ARB_GRANT: begin
                if (!owner_req || (burst_last && others_req)) begin
                    state_d = S_ARB_SWITCH;
                    gnt_d   = '0;
                    burst_d = '0;
                end else begin
                    burst_d = burst_last ? '0 : burst_q + BURST_W'(1);
                end
            end
            default: begin
                state_d = S_ARB_IDLE;
                gnt_d   = '0;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_ARB_IDLE;
            gnt_o   <= '0;
            owner_o <= CW'(DEFAULT_CLIENT);
            burst_q <= '0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_o   <= gnt_d;
            owner_o <= owner_d;
            burst_q <= burst_d;
            busy_o  <= |gnt_d;
        end
    end

    // SRAM port mux, driven from the registered owner.
    always_comb begin
        SRAM_address    = addr_i[DEFAULT_CLIENT*ADDR_W +: ADDR_W];
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (state_q == S_ARB_GRANT) begin
            SRAM_address    = addr_i[32'(owner_o)*ADDR_W +: ADDR_W];
            SRAM_write_data = wdata_i[32'(owner_o)*DATA_W +: DATA_W];
            SRAM_we_n       = we_n_i[owner_o];
        end
    end

    always_comb begin
        tag_in.valid = (state_q == S_ARB_GRANT) && we_n_i[owner_o];
        tag_in.owner = TAG_OWNER_W'(owner_o);
        tag_tail     = tag_pipe[PIPE_D-1];
        if (READ_LATENCY == 1) tag_tail = tag_in;
    end

    // Tag pipe: the last stage is decoded straight into the registered rvalid strobe.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(PIPE_D); i++) tag_pipe[i] <= '0;
            rvalid_o <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < int'(PIPE_D); i++) tag_pipe[i] <= tag_pipe[i-1];
            rvalid_o <= tag_tail.valid ? (NUM_CLIENTS'(1) << tag_tail.owner) : '0;
        end
    end

endmodule

// File: doc/sram_client_arbiter.md
# sram_client_arbiter

Parametrised N-client arbiter for the single external SRAM port that the UART, LDD, IDCT, CSC and VGA units share. It replaces the hard-wired top-state SRAM mux with request/grant handshakes, selectable fixed-priority or round-robin arbitration, a burst limit, and a turnaround cycle on every ownership change. It also tags read data so that each client receives its own SRAM reads. It sits between the client units and SRAM_controller.

## Interface
- NUM_CLIENTS, 4, number of requesters (2..8)
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- READ_LATENCY, 2, cycles from address presented to SRAM_read_data valid (SRAM_controller)
- MAX_BURST, 256, max consecutive granted cycles before preemption (≥2)
- DEFAULT_CLIENT, NUM_CLIENTS-1, client whose address drives SRAM when nobody is granted (VGA)

Ports:
- CLOCK_50_I  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- mode_i  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- req_i  in  NUM_CLIENTS  per-client access request
- addr_i  in  NUM_CLIENTS*ADDR_W  flattened client addresses, client k at [k*ADDR_W +: ADDR_W]
- wdata_i  in  NUM_CLIENTS*DATA_W  flattened client write data
- we_n_i  in  NUM_CLIENTS  per-client write enable, active-low
- gnt_o  out  NUM_CLIENTS  one-hot grant, registered
- rvalid_o  out  NUM_CLIENTS  one-hot strobe: SRAM_read_data belongs to client k this cycle
- owner_o  out  $clog2(NUM_CLIENTS)  index of current or last owner
- busy_o  out  1  high when any grant is active
- SRAM_address  out  ADDR_W  to SRAM_controller
- SRAM_write_data  out  DATA_W  to SRAM_controller
- SRAM_we_n  out  1  to SRAM_controller

## Operation
- FSM states:
  - S_ARB_IDLE: no grant; if any req_i is set, pick a winner, register gnt_o and go to S_ARB_GRANT.
  - S_ARB_GRANT: grant held while the owner's req_i stays high.
  - S_ARB_SWITCH: one dead cycle with gnt_o = 0 and SRAM_we_n = 1.
- GRANT exits to SWITCH when:
  - the owner drops req_i; or
  - the burst counter reaches MAX_BURST-1 and another client is requesting (preemption).
- Burst limit with no other requester: counter wraps to 0 and the grant is kept.
- SWITCH exit: re-arbitrates; goes to GRANT if any req_i is set, else IDLE. A preempted owner whose req is still high competes normally.
- Winner selection:
  - Fixed priority: lowest requesting index.
  - Round-robin: first requester searching from (last owner+1) mod NUM_CLIENTS.
  - mode_i is sampled only at arbitration instants.
- SRAM mux (combinational from registered owner):
  - Granted: owner's address, data and we_n.
  - Not granted: addr of DEFAULT_CLIENT, write data 0, SRAM_we_n = 1.
- Non-owners' we_n_i is ignored.
- Read tagging:
  - Each granted cycle with owner we_n_i = 1 pushes {1, owner} into a READ_LATENCY-deep shift register; all other cycles push {0, x}.
  - The tail drives rvalid_o, so a client sees data exactly READ_LATENCY cycles after its read address.
  - Reads in flight across a switch still deliver to the original client.
- Reset values: gnt_o = 0, rvalid_o = 0, owner_o = DEFAULT_CLIENT, busy_o = 0, SRAM_we_n = 1, SRAM_address = DEFAULT_CLIENT address, burst counter 0, tag pipe cleared, round-robin pointer = DEFAULT_CLIENT.
- Reset mid-burst or mid-read: pending rvalid is discarded. No write is issued after resetn falls.

## Timing
- req_i rises and is sampled at edge t in IDLE → gnt_o high after edge t; client drives its address from cycle t+1.
- Owner drops req at edge t → SWITCH during cycle t+1, next grant at edge t+2. Minimum handover gap is one cycle.
- Owner may not drop req_i and assert a write in the same cycle. Req and address are read on the same edge.
- Preemption: an owner granted for MAX_BURST cycles loses gnt_o at the following edge. The client must stall once gnt_o falls.
- Read: address at cycle c with gnt → rvalid_o[k] at cycle c+READ_LATENCY.
- Simultaneous release and new requests: resolved in the SWITCH cycle, never in GRANT.

## Structure
- Package sram_arb_pkg holds:
  - arb_state_t enum (S_ARB_IDLE, S_ARB_GRANT, S_ARB_SWITCH);
  - CLIENT_W function ($clog2 wrapper);
  - the tag struct {valid, owner}.
- Sub-module sram_arb_picker: combinational winner select from (req, mode, last owner) → winner index plus found flag. The FSM, counter, mux and tag pipe live in sram_client_arbiter.

## Test plan
- Reset: hold resetn low with req_i = 4'b1111 → gnt_o = 0, SRAM_we_n = 1, rvalid_o = 0. First grant goes to client 0 one cycle after release (mode 0).
- Fixed priority: req_i = 4'b1010 → client 1 granted. Drop req 1 → one SWITCH cycle with gnt_o = 0, then client 3 granted at +2.
- Round-robin: mode_i = 1, all clients requesting, each dropping req after 3 cycles → grant order 0, 1, 2, 3, 0, with 1 dead cycle between each.
- Burst preemption (MAX_BURST = 8): client 2 holds req while client 0 requests → client 2 loses gnt after 8 cycles and client 0 granted after SWITCH. With client 2 alone, its grant is never dropped.
- Read tagging: client 1 reads addresses 100..103, is preempted, then client 3 writes → rvalid_o[1] pulses 4 times 2 cycles after each read address. rvalid_o[3] stays 0 and SRAM_we_n is 1 during SWITCH.
- Mid-operation reset: assert resetn during a client 2 read burst → no rvalid_o after reset, all outputs at reset values within the same cycle.
